// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
//   Shared definitions for the execute-side branch stage:
//   - bit positions of the ALU flag vector {v,c,n,z}
//   - conditional-branch funct3 encodings
//   - squash FSM state encoding
// ---------------------------------------------------------------------------
package ex_pkg;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

endpackage

// File: rtl/branch_cond.sv
// ---------------------------------------------------------------------------
// branch_cond
//   Combinational branch-condition evaluator. The flags come from the ALU
//   computing a-b, so signed less-than is n^v and unsigned less-than is a
//   missing carry (borrow).
//   Ports:
//     funct3 in  3  branch condition select
//     flags  in  4  {v,c,n,z}
//     cond   out 1  condition holds (0 for the unused codes 010/011)
// ---------------------------------------------------------------------------
module branch_cond
    import ex_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [3:0] flags,
    output logic       cond
);

    // Decode the funct3 code against the flag vector.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = flags[FLAG_Z];
            F3_BNE:  cond = ~flags[FLAG_Z];
            F3_BLT:  cond = flags[FLAG_N] ^ flags[FLAG_V];
            F3_BGE:  cond = ~(flags[FLAG_N] ^ flags[FLAG_V]);
            F3_BLTU: cond = ~flags[FLAG_C];
            F3_BGEU: cond = flags[FLAG_C];
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_branch_stage.sv
// ---------------------------------------------------------------------------
// ex_branch_stage
//   Branch resolver plus EX/MEM pipeline register behind the ALU.
//   Resolves beq/bne/blt/bge/bltu/bgeu/jal/jalr, registers a one-cycle
//   redirect to fetch, squashes SQUASH_DEPTH wrong-path instructions and
//   latches the surviving instruction into MEM under stall/flush control.
//   Ports:
//     clk, reset (sync, active-high)
//     ex_*        EX-slot instruction and controls
//     alu_result  ALU output (jalr base+imm), alu_flags {v,c,n,z} of a-b
//     mem_stall   hold everything, ext_flush kill MEM slot and squash FSM
//     mem_*       registered MEM-slot outputs
//     redirect_*  registered fetch redirect (one-cycle pulse)
// ---------------------------------------------------------------------------
module ex_branch_stage
    import ex_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_regwrite,
    input  logic            ex_memwrite,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_writedata,
    input  logic [XLEN-1:0] alu_result,
    input  logic [3:0]      alu_flags,
    input  logic            mem_stall,
    input  logic            ext_flush,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_writedata,
    output logic [4:0]      mem_rd,
    output logic            mem_regwrite,
    output logic            mem_memwrite,
    output logic            mem_misalign,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] LSB_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [2:0]      DEPTH     = 3'(SQUASH_DEPTH);

    state_e          state_q;
    logic [2:0]      cnt_q;

    logic            mem_valid_q,     mem_valid_d;
    logic [XLEN-1:0] mem_result_q,    mem_result_d;
    logic [XLEN-1:0] mem_writedata_q, mem_writedata_d;
    logic [4:0]      mem_rd_q,        mem_rd_d;
    logic            mem_regwrite_q,  mem_regwrite_d;
    logic            mem_memwrite_q,  mem_memwrite_d;
    logic            mem_misalign_q,  mem_misalign_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q,   redirect_pc_d;

    logic            cond_s;
    logic            eff_valid_s;
    logic            link_s;
    logic            taken_s;
    logic            misalign_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] result_s;

    branch_cond u_branch_cond (
        .funct3 (ex_funct3),
        .flags  (alu_flags),
        .cond   (cond_s)
    );

    // Resolve the EX instruction: validity, target, taken and alignment.
    always_comb begin
        eff_valid_s = ex_valid & (state_q == ST_RUN);
        link_s      = ex_jump | ex_jalr;
        if (ex_jalr) begin
            target_s = alu_result & LSB_CLEAR;
        end else begin
            target_s = ex_pc + ex_imm;
        end
        taken_s    = eff_valid_s & (link_s | (ex_branch & cond_s));
        misalign_s = taken_s & (target_s[1:0] != 2'b00);
        result_s   = link_s ? (ex_pc + PC_STEP) : alu_result;
    end

    // Next-state of the MEM slot and redirect: flush > stall > advance.
    always_comb begin
        mem_valid_d      = mem_valid_q;
        mem_result_d     = mem_result_q;
        mem_writedata_d  = mem_writedata_q;
        mem_rd_d         = mem_rd_q;
        mem_regwrite_d   = mem_regwrite_q;
        mem_memwrite_d   = mem_memwrite_q;
        mem_misalign_d   = mem_misalign_q;
        redirect_pc_d    = redirect_pc_q;
        redirect_valid_d = 1'b0;
        if (ext_flush) begin
            mem_valid_d    = 1'b0;
            mem_regwrite_d = 1'b0;
            mem_memwrite_d = 1'b0;
            mem_misalign_d = 1'b0;
        end else if (mem_stall) begin
            redirect_valid_d = 1'b0;
        end else begin
            mem_valid_d      = eff_valid_s;
            mem_result_d     = result_s;
            mem_writedata_d  = ex_writedata;
            mem_rd_d         = ex_rd;
            mem_regwrite_d   = eff_valid_s & ex_regwrite;
            mem_memwrite_d   = eff_valid_s & ex_memwrite;
            mem_misalign_d   = misalign_s;
            redirect_valid_d = taken_s & ~misalign_s;
            // Target is kept even when misaligned so a trap handler can see it.
            if (taken_s) begin
                redirect_pc_d = target_s;
            end else begin
                redirect_pc_d = redirect_pc_q;
            end
        end
    end

    // MEM-slot and redirect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q      <= 1'b0;
            mem_result_q     <= '0;
            mem_writedata_q  <= '0;
            mem_rd_q         <= 5'd0;
            mem_regwrite_q   <= 1'b0;
            mem_memwrite_q   <= 1'b0;
            mem_misalign_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mem_valid_q      <= mem_valid_d;
            mem_result_q     <= mem_result_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_rd_q         <= mem_rd_d;
            mem_regwrite_q   <= mem_regwrite_d;
            mem_memwrite_q   <= mem_memwrite_d;
            mem_misalign_q   <= mem_misalign_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Squash FSM: enters SQUASH on the same edge that registers a redirect,
    // then burns one EX slot per non-stalled cycle until the count runs out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else if (ext_flush) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else if (mem_stall) begin
            state_q <= state_q;
            cnt_q   <= cnt_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (taken_s & ~misalign_s) begin
                        state_q <= ST_SQUASH;
                        cnt_q   <= DEPTH;
                    end else begin
                        state_q <= ST_RUN;
                        cnt_q   <= 3'd0;
                    end
                end
                ST_SQUASH: begin
                    if (cnt_q <= 3'd1) begin
                        state_q <= ST_RUN;
                        cnt_q   <= 3'd0;
                    end else begin
                        state_q <= ST_SQUASH;
                        cnt_q   <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_result     = mem_result_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_rd         = mem_rd_q;
    assign mem_regwrite   = mem_regwrite_q;
    assign mem_memwrite   = mem_memwrite_q;
    assign mem_misalign   = mem_misalign_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_branch_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_branch_stage
//   Directed self-checking bench for ex_branch_stage with hand-computed
//   expected values.
// ---------------------------------------------------------------------------
module tb_ex_branch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_jalr;
    logic [2:0]  ex_funct3;
    logic        ex_regwrite;
    logic        ex_memwrite;
    logic [4:0]  ex_rd;
    logic [31:0] ex_writedata;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        mem_stall;
    logic        ext_flush;
    logic        mem_valid;
    logic [31:0] mem_result;
    logic [31:0] mem_writedata;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic        mem_memwrite;
    logic        mem_misalign;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    ex_branch_stage #(.XLEN(32), .SQUASH_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_jalr        (ex_jalr),
        .ex_funct3      (ex_funct3),
        .ex_regwrite    (ex_regwrite),
        .ex_memwrite    (ex_memwrite),
        .ex_rd          (ex_rd),
        .ex_writedata   (ex_writedata),
        .alu_result     (alu_result),
        .alu_flags      (alu_flags),
        .mem_stall      (mem_stall),
        .ext_flush      (ext_flush),
        .mem_valid      (mem_valid),
        .mem_result     (mem_result),
        .mem_writedata  (mem_writedata),
        .mem_rd         (mem_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_memwrite   (mem_memwrite),
        .mem_misalign   (mem_misalign),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ex_valid = 1'b0; ex_pc = 32'h0; ex_imm = 32'h0;
        ex_branch = 1'b0; ex_jump = 1'b0; ex_jalr = 1'b0;
        ex_funct3 = 3'b000; ex_regwrite = 1'b0; ex_memwrite = 1'b0;
        ex_rd = 5'd0; ex_writedata = 32'h0; alu_result = 32'h0;
        alu_flags = 4'b0000;
    endtask

    task automatic set_alu(input logic [31:0] res, input logic [4:0] rd);
        clr();
        ex_valid = 1'b1; ex_pc = 32'h0000_0F00; ex_regwrite = 1'b1;
        ex_rd = rd; alu_result = res;
    endtask

    task automatic set_br(input logic [31:0] pc, input logic [31:0] imm,
                          input logic [2:0] f3, input logic [3:0] flags);
        clr();
        ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = pc; ex_imm = imm;
        ex_funct3 = f3; alu_flags = flags;
    endtask

    initial begin
        logic [7:0] exp_c0;
        logic [7:0] exp_c1;
        clr();
        reset = 1'b1; mem_stall = 1'b0; ext_flush = 1'b0;

        // Reset state
        cyc();
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_mem_result", mem_result, 32'd0);
        chk("rst_misalign", {31'd0, mem_misalign}, 32'd0);
        reset = 1'b0;

        // beq taken, then two wrong-path slots (a taken beq with regwrite) dropped
        set_br(32'h100, 32'h20, 3'b000, 4'b0001);
        cyc();
        chk("beq_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("beq_pc", redirect_pc, 32'h120);
        chk("beq_mem_valid", {31'd0, mem_valid}, 32'd1);
        set_br(32'h140, 32'h80, 3'b000, 4'b0001);
        ex_regwrite = 1'b1;
        cyc();
        chk("sq1_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("sq1_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("sq1_regwrite", {31'd0, mem_regwrite}, 32'd0);
        cyc();
        chk("sq2_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("sq2_redirect", {31'd0, redirect_valid}, 32'd0);
        set_alu(32'h55, 5'd5);
        cyc();
        chk("post_sq_valid", {31'd0, mem_valid}, 32'd1);
        chk("post_sq_result", mem_result, 32'h55);
        chk("post_sq_rd", {27'd0, mem_rd}, 32'd5);
        chk("post_sq_regwrite", {31'd0, mem_regwrite}, 32'd1);

        // blt taken on overflow (v=1, n=0), backward target
        set_br(32'h200, 32'hFFFF_FFF0, 3'b100, 4'b1000);
        cyc();
        chk("blt_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("blt_pc", redirect_pc, 32'h1F0);
        clr();
        cyc();
        cyc();
        chk("blt_sq_valid", {31'd0, mem_valid}, 32'd0);
        set_br(32'h210, 32'h40, 3'b100, 4'b0000);
        alu_result = 32'h7;
        cyc();
        chk("blt_nt_valid", {31'd0, mem_valid}, 32'd1);
        chk("blt_nt_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("blt_nt_result", mem_result, 32'h7);

        // jalr to 0x203 -> target 0x202 (misaligned): link value, no redirect
        clr();
        ex_valid = 1'b1; ex_jalr = 1'b1; ex_pc = 32'h300;
        alu_result = 32'h203; ex_regwrite = 1'b1; ex_rd = 5'd1;
        cyc();
        chk("jalr_mis_pc", redirect_pc, 32'h202);
        chk("jalr_mis_result", mem_result, 32'h304);
        chk("jalr_mis_flag", {31'd0, mem_misalign}, 32'd1);
        chk("jalr_mis_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("jalr_mis_valid", {31'd0, mem_valid}, 32'd1);

        // jal to pc+6: misaligned, still enters MEM, no squash afterwards
        clr();
        ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 32'h400; ex_imm = 32'h6;
        cyc();
        chk("jal_mis_flag", {31'd0, mem_misalign}, 32'd1);
        chk("jal_mis_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("jal_mis_result", mem_result, 32'h404);
        set_alu(32'h42, 5'd4);
        cyc();
        chk("jal_mis_next_valid", {31'd0, mem_valid}, 32'd1);
        chk("jal_mis_next_flag", {31'd0, mem_misalign}, 32'd0);

        // aligned jalr: 0x2F1 -> 0x2F0
        clr();
        ex_valid = 1'b1; ex_jalr = 1'b1; ex_pc = 32'h320; alu_result = 32'h2F1;
        cyc();
        chk("jalr_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("jalr_pc", redirect_pc, 32'h2F0);
        chk("jalr_result", mem_result, 32'h324);
        clr();
        cyc();
        cyc();

        // mem_stall held 3 cycles over a taken bne
        set_alu(32'h99, 5'd9);
        cyc();
        chk("pre_stall_result", mem_result, 32'h99);
        set_br(32'h500, 32'h40, 3'b001, 4'b0000);
        alu_result = 32'h11;
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_redirect", {31'd0, redirect_valid}, 32'd0);
            chk("stall_mem_valid", {31'd0, mem_valid}, 32'd1);
            chk("stall_mem_result", mem_result, 32'h99);
            chk("stall_mem_rd", {27'd0, mem_rd}, 32'd9);
        end
        mem_stall = 1'b0;
        cyc();
        chk("bne_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("bne_pc", redirect_pc, 32'h540);
        chk("bne_result", mem_result, 32'h11);
        clr();
        cyc();
        chk("bne_pulse_end", {31'd0, redirect_valid}, 32'd0);
        cyc();

        // ext_flush during SQUASH with count=1
        set_br(32'h600, 32'h10, 3'b000, 4'b0001);
        cyc();
        chk("fl1_redirect", {31'd0, redirect_valid}, 32'd1);
        set_alu(32'h33, 5'd3);
        cyc();
        chk("fl1_drop", {31'd0, mem_valid}, 32'd0);
        ext_flush = 1'b1;
        cyc();
        chk("fl1_flush_valid", {31'd0, mem_valid}, 32'd0);
        chk("fl1_flush_redirect", {31'd0, redirect_valid}, 32'd0);
        ext_flush = 1'b0;
        set_alu(32'h77, 5'd7);
        cyc();
        chk("fl1_accept_valid", {31'd0, mem_valid}, 32'd1);
        chk("fl1_accept_result", mem_result, 32'h77);

        // ext_flush at count=2 also returns the FSM to RUN
        set_br(32'h640, 32'h10, 3'b000, 4'b0001);
        cyc();
        chk("fl2_redirect", {31'd0, redirect_valid}, 32'd1);
        clr();
        ext_flush = 1'b1;
        cyc();
        ext_flush = 1'b0;
        set_alu(32'h66, 5'd6);
        cyc();
        chk("fl2_accept_valid", {31'd0, mem_valid}, 32'd1);
        chk("fl2_accept_result", mem_result, 32'h66);

        // reset mid-squash returns to RUN
        set_br(32'h700, 32'h4, 3'b000, 4'b0001);
        cyc();
        chk("rsq_redirect", {31'd0, redirect_valid}, 32'd1);
        clr();
        reset = 1'b1;
        cyc();
        chk("rsq_valid", {31'd0, mem_valid}, 32'd0);
        chk("rsq_redirect_clr", {31'd0, redirect_valid}, 32'd0);
        reset = 1'b0;
        set_alu(32'h88, 5'd8);
        cyc();
        chk("rsq_accept", {31'd0, mem_valid}, 32'd1);
        chk("rsq_result", mem_result, 32'h88);

        // funct3 sweep with c=0 and c=1 (n=v=z=0); bit k = taken for code k
        exp_c0 = 8'b0110_0010;
        exp_c1 = 8'b1010_0010;
        for (int f = 0; f < 8; f++) begin
            set_br(32'h800, 32'h8, 3'(f), 4'b0000);
            cyc();
            chk($sformatf("sweep_c0_f%0d", f), {31'd0, redirect_valid}, {31'd0, exp_c0[f]});
            clr();
            cyc();
            cyc();
            set_br(32'h800, 32'h8, 3'(f), 4'b0100);
            cyc();
            chk($sformatf("sweep_c1_f%0d", f), {31'd0, redirect_valid}, {31'd0, exp_c1[f]});
            clr();
            cyc();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
